mem_port_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arb_req_hold.sv | 77 +++++++
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared definitions for the unified memory-port arbiter.
//                Holds the grant-state encoding, the enable-bit positions
//                inside the read/write control buses, and the default
//                control code driven for an instruction fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Grant state of the shared port
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_GNT = 2'd1,
        D_GNT = 2'd2
    } arb_state_t;

    // Enable-bit positions in the read (4-bit) and write (3-bit) controls
    localparam int READ_EN_BIT  = 3;
    localparam int WRITE_EN_BIT = 2;

    // Word read: enable bit set, funct3 = 3'b010
    localparam logic [3:0] IFETCH_CTRL_DEFAULT = 4'b1010;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_req_hold.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_req_hold
//  Description : Hold registers for the requester that currently owns the
//                memory port. Address, controls and store data are captured
//                once when a grant is made, so the memory side sees stable
//                values for the whole transaction regardless of what the
//                requester does meanwhile.
//  Ports       : CLK, RESET         - clock, synchronous active-high reset
//                i_load_fetch       - capture a fetch transaction
//                i_load_data        - capture a data transaction
//                i_release          - transaction completed, drop controls
//                i_fetch_addr       - fetch address
//                i_d_read/i_d_write - data read/write controls
//                i_d_addr           - data address
//                i_d_writedata      - store data
//                o_m_*              - registered memory-port drive
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_req_hold
    import mem_arb_pkg::*;
#(
    parameter logic [3:0] IFETCH_CTRL = IFETCH_CTRL_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        i_load_fetch,
    input  logic        i_load_data,
    input  logic        i_release,
    input  logic [31:0] i_fetch_addr,
    input  logic [3:0]  i_d_read,
    input  logic [2:0]  i_d_write,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_writedata,
    output logic [3:0]  o_m_read,
    output logic [2:0]  o_m_write,
    output logic [31:0] o_m_addr,
    output logic [31:0] o_m_writedata
);

    logic [3:0]  r_read;
    logic [2:0]  r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    // Only the controls are dropped on completion so the memory does not
    // see a second request during the idle cycle between grants. Address
    // and data simply keep their last value until the next capture.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_read  <= '0;
            r_write <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (i_load_data) begin
            r_read  <= i_d_read;
            r_write <= i_d_write;
            r_addr  <= i_d_addr;
            r_wdata <= i_d_writedata;
        end else if (i_load_fetch) begin
            r_read  <= IFETCH_CTRL;
            r_write <= '0;
            r_addr  <= i_fetch_addr;
            r_wdata <= '0;
        end else if (i_release) begin
            r_read  <= '0;
            r_write <= '0;
        end
    end

    assign o_m_read      = r_read;
    assign o_m_write     = r_write;
    assign o_m_addr      = r_addr;
    assign o_m_writedata = r_wdata;

endmodule : mem_arb_req_hold
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one 32-bit memory port between the CPU instruction
//                fetch port and data port. Data has priority; after
//                MAX_D_STREAK consecutive data grants with a fetch waiting,
//                the fetch is served next. Each transaction ends on a
//                single-cycle M_ACK and is followed by one idle cycle.
//  Ports       : CLK, RESET                 - clock, sync active-high reset
//                I_READ/I_ADDR              - fetch request / address
//                I_READDATA/I_BUSYWAIT      - fetch data / stall
//                D_READ/D_WRITE             - data controls (enable in MSB)
//                D_ADDR/D_WRITEDATA         - data address / store data
//                D_READDATA/D_BUSYWAIT      - load data / stall
//                M_READ/M_WRITE/M_ADDR/
//                M_WRITEDATA                - registered memory drive
//                M_READDATA/M_ACK           - memory response
//                PERF_*                     - performance counters (optional)
//  Options     : MEM_ARB_PERF_CNT_EN - adds PERF_I_GRANTS, PERF_D_GRANTS,
//                PERF_I_STALL, PERF_D_STALL (32-bit, wrapping).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int         MAX_D_STREAK = 4,
    parameter logic [3:0] IFETCH_CTRL  = IFETCH_CTRL_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        I_READ,
    input  logic [31:0] I_ADDR,
    output logic [31:0] I_READDATA,
    output logic        I_BUSYWAIT,
    input  logic [3:0]  D_READ,
    input  logic [2:0]  D_WRITE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WRITEDATA,
    output logic [31:0] D_READDATA,
    output logic        D_BUSYWAIT,
    output logic [3:0]  M_READ,
    output logic [2:0]  M_WRITE,
    output logic [31:0] M_ADDR,
    output logic [31:0] M_WRITEDATA,
    input  logic [31:0] M_READDATA,
    input  logic        M_ACK
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0] PERF_I_GRANTS,
    output logic [31:0] PERF_D_GRANTS,
    output logic [31:0] PERF_I_STALL,
    output logic [31:0] PERF_D_STALL
`endif
);

    localparam int                c_STREAK_W   = $clog2(MAX_D_STREAK + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_D_STREAK);

    arb_state_t             r_state;
    arb_state_t             w_state_next;
    logic [c_STREAK_W-1:0]  r_d_streak;
    logic [c_STREAK_W-1:0]  w_d_streak_next;

    logic        w_d_req;
    logic        w_streak_full;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_release;
    logic        w_i_done;
    logic        w_d_done;
    logic [2:0]  w_m_write;

    assign w_d_req       = D_READ[READ_EN_BIT] | D_WRITE[WRITE_EN_BIT];
    assign w_streak_full = (r_d_streak == c_STREAK_MAX);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_d_streak <= '0;
        end else begin
            r_state    <= w_state_next;
            r_d_streak <= w_d_streak_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, grant strobes and streak bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_d_streak_next = r_d_streak;
        w_grant_i       = 1'b0;
        w_grant_d       = 1'b0;

        case (r_state)
            IDLE: begin
                // A full streak with a fetch waiting yields to the fetch
                if (w_d_req && !(I_READ && w_streak_full)) begin
                    w_state_next = D_GNT;
                    w_grant_d    = 1'b1;
                    if (!I_READ) begin
                        w_d_streak_next = '0;
                    end else if (!w_streak_full) begin
                        w_d_streak_next = r_d_streak + c_STREAK_W'(1);
                    end
                end else if (I_READ) begin
                    w_state_next    = I_GNT;
                    w_grant_i       = 1'b1;
                    w_d_streak_next = '0;
                end else begin
                    w_d_streak_next = '0;
                end
            end
            I_GNT: begin
                if (M_ACK) begin
                    w_state_next = IDLE;
                end
            end
            D_GNT: begin
                if (M_ACK) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_release = (r_state != IDLE) && M_ACK;
    assign w_i_done  = (r_state == I_GNT) && M_ACK;
    assign w_d_done  = (r_state == D_GNT) && M_ACK;

    // ------------------------------------------------------------------
    // Captured transaction drives the memory port
    // ------------------------------------------------------------------
    mem_arb_req_hold #(
        .IFETCH_CTRL (IFETCH_CTRL)
    ) u_req_hold (
        .CLK           (CLK),
        .RESET         (RESET),
        .i_load_fetch  (w_grant_i),
        .i_load_data   (w_grant_d),
        .i_release     (w_release),
        .i_fetch_addr  (I_ADDR),
        .i_d_read      (D_READ),
        .i_d_write     (D_WRITE),
        .i_d_addr      (D_ADDR),
        .i_d_writedata (D_WRITEDATA),
        .o_m_read      (M_READ),
        .o_m_write     (w_m_write),
        .o_m_addr      (M_ADDR),
        .o_m_writedata (M_WRITEDATA)
    );

    assign M_WRITE = w_m_write;

    // ------------------------------------------------------------------
    // Stalls and read data returned to the CPU
    // ------------------------------------------------------------------
    assign I_BUSYWAIT = I_READ  & ~w_i_done;
    assign D_BUSYWAIT = w_d_req & ~w_d_done;

    assign I_READDATA = w_i_done ? M_READDATA : '0;
    // A store's memory response carries no load data
    assign D_READDATA = (w_d_done && !w_m_write[WRITE_EN_BIT]) ? M_READDATA : '0;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] r_perf_i_grants;
    logic [31:0] r_perf_d_grants;
    logic [31:0] r_perf_i_stall;
    logic [31:0] r_perf_d_stall;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_perf_i_grants <= '0;
            r_perf_d_grants <= '0;
            r_perf_i_stall  <= '0;
            r_perf_d_stall  <= '0;
        end else begin
            if (w_grant_i)  r_perf_i_grants <= r_perf_i_grants + 32'd1;
            if (w_grant_d)  r_perf_d_grants <= r_perf_d_grants + 32'd1;
            if (I_BUSYWAIT) r_perf_i_stall  <= r_perf_i_stall  + 32'd1;
            if (D_BUSYWAIT) r_perf_d_stall  <= r_perf_d_stall  + 32'd1;
        end
    end

    assign PERF_I_GRANTS = r_perf_i_grants;
    assign PERF_D_GRANTS = r_perf_d_grants;
    assign PERF_I_STALL  = r_perf_i_stall;
    assign PERF_D_STALL  = r_perf_d_stall;
`endif

endmodule : mem_port_arbiter
`default_nettype wire
